// File: rtl/reg_file_pkg.sv
// Shared system definitions: register roles, UART config field layout and
// reset images used by the register file, the controller and the UART.
package reg_file_pkg;

  // Fixed roles of the first four register-file locations.
  typedef enum logic [1:0] {
    ALU_OPA   = 2'd0,
    ALU_OPB   = 2'd1,
    UART_CFG  = 2'd2,
    DIV_RATIO = 2'd3
  } reg_idx_e;

  // UART config (location 2) field positions.
  localparam int unsigned CFG_PAR_EN_BIT   = 0;
  localparam int unsigned CFG_PAR_TYPE_BIT = 1;  // 0 = even, 1 = odd
  localparam int unsigned CFG_PRESCALE_LSB = 2;

  // Reset-time UART settings: parity enabled, even, prescale 32.
  localparam int unsigned UART_PAR_EN_RST   = 1;
  localparam int unsigned UART_PAR_ODD_RST  = 0;
  localparam int unsigned UART_PRESCALE_RST = 32;

  localparam logic [7:0] UART_CFG_RST = 8'((UART_PRESCALE_RST << CFG_PRESCALE_LSB) |
                                           (UART_PAR_ODD_RST  << CFG_PAR_TYPE_BIT) |
                                           (UART_PAR_EN_RST   << CFG_PAR_EN_BIT));
  localparam logic [7:0] DIV_RATIO_RST = 8'h20;

  // Reset image of one location; everything not listed resets to zero.
  function automatic logic [31:0] reset_value(input int unsigned idx);
    logic [31:0] v;
    v = '0;
    if (idx == 32'(UART_CFG)) begin
      v = 32'(UART_CFG_RST);
    end else if (idx == 32'(DIV_RATIO)) begin
      v = 32'(DIV_RATIO_RST);
    end
    return v;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: flat DEPTH x DW register array, single address port shared by
// one write and one read per cycle, registered read data with a valid pulse,
// and direct views of the four system-role locations.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DW     = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DW-1:0]     wr_data,
  output logic [DW-1:0]     regfile_out,
  output logic              regfile_out_valid,
  output logic [DW-1:0]     REG0,
  output logic [DW-1:0]     REG1,
  output logic [DW-1:0]     REG2,
  output logic [DW-1:0]     REG3
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned DEPTH_U = DEPTH;

  if (DEPTH < 4 || DEPTH > (1 << ADDR_W)) begin : g_depth_chk
    $error("reg_file: DEPTH must be within 4 .. 2**ADDR_W");
  end

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             do_write;
  logic             do_read;

  assign idx      = Addr[IDX_W-1:0];
  assign in_range = (32'(Addr) < DEPTH_U);
  // A simultaneous read request loses to the write; out-of-range writes vanish.
  assign do_write = wr_en & in_range;
  assign do_read  = rd_en & ~wr_en;

  // Next-state of the storage array.
  always_comb begin
    mem_d = mem_q;
    if (do_write) begin
      mem_d[idx] = wr_data;
    end
  end

  // Read data/valid next-state: data holds unless a read completes.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (do_read) begin
      rvalid_d = 1'b1;
      rdata_d  = in_range ? mem_q[idx] : '0;
    end
  end

  // State registers; reset wins over any pending access.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH_U; i++) begin
        mem_q[IDX_W'(i)] <= DW'(reset_value(i));
      end
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign regfile_out       = rdata_q;
  assign regfile_out_valid = rvalid_q;

  assign REG0 = mem_q[IDX_W'(ALU_OPA)];
  assign REG1 = mem_q[IDX_W'(ALU_OPB)];
  assign REG2 = mem_q[IDX_W'(UART_CFG)];
  assign REG3 = mem_q[IDX_W'(DIV_RATIO)];

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: a DEPTH=16 and a DEPTH=8 instance share one stimulus
// stream; a directed vector table plus a random tail are checked against a
// reference memory model and a read-result scoreboard.
module tb_reg_file;

  logic       CLK = 1'b0;
  logic       RST, wr_en, rd_en;
  logic [3:0] Addr;
  logic [7:0] wr_data;

  logic [7:0] out16, out8;
  logic       v16, v8;
  logic [7:0] r0_16, r1_16, r2_16, r3_16;
  logic [7:0] r0_8, r1_8, r2_8, r3_8;

  always #5 CLK = ~CLK;

  reg_file #(.DW(8), .ADDR_W(4), .DEPTH(16)) u_dut16 (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .rd_en(rd_en), .Addr(Addr), .wr_data(wr_data),
    .regfile_out(out16), .regfile_out_valid(v16),
    .REG0(r0_16), .REG1(r1_16), .REG2(r2_16), .REG3(r3_16)
  );

  reg_file #(.DW(8), .ADDR_W(4), .DEPTH(8)) u_dut8 (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .rd_en(rd_en), .Addr(Addr), .wr_data(wr_data),
    .regfile_out(out8), .regfile_out_valid(v8),
    .REG0(r0_8), .REG1(r1_8), .REG2(r2_8), .REG3(r3_8)
  );

  int errors = 0;
  int checks = 0;

  // Reference model of both instances.
  logic [7:0] m16 [16];
  logic [7:0] m8  [8];
  logic [7:0] hold16, hold8;
  logic       exp_valid;

  typedef struct packed {
    logic [7:0] d16;
    logic [7:0] d8;
  } rd_exp_t;
  rd_exp_t sb[$];

  typedef struct {
    logic       rst;
    logic       wr;
    logic       rd;
    logic [3:0] a;
    logic [7:0] d;
    logic       ev;
    logic [7:0] ed16;
    logic [7:0] ed8;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m16[i] = 8'h00;
    for (int i = 0; i < 8; i++)  m8[i]  = 8'h00;
    m16[2] = 8'h81; m16[3] = 8'h20;
    m8[2]  = 8'h81; m8[3]  = 8'h20;
    hold16 = 8'h00;
    hold8  = 8'h00;
  endtask

  // Apply one cycle of stimulus, advance the model, check all outputs #1 after the edge.
  task automatic drive(input logic rst, input logic wr, input logic rd,
                       input logic [3:0] a, input logic [7:0] d);
    rd_exp_t e;
    RST = rst; wr_en = wr; rd_en = rd; Addr = a; wr_data = d;
    exp_valid = !rst && rd && !wr;
    if (rst) begin
      model_reset();
      sb.delete();
    end else if (exp_valid) begin
      e.d16 = m16[a];
      e.d8  = (a < 4'd8) ? m8[a[2:0]] : 8'h00;
      sb.push_back(e);
      hold16 = e.d16;
      hold8  = e.d8;
    end else if (wr) begin
      m16[a] = d;
      if (a < 4'd8) m8[a[2:0]] = d;
    end
    @(posedge CLK);
    #1;
    chk("valid16", 32'(v16), 32'(exp_valid));
    chk("valid8", 32'(v8), 32'(exp_valid));
    if (v16) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(v16), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rdata16", 32'(out16), 32'(e.d16));
        chk("rdata8", 32'(out8), 32'(e.d8));
      end
    end else begin
      chk("hold16", 32'(out16), 32'(hold16));
      chk("hold8", 32'(out8), 32'(hold8));
    end
    chk("REG0_16", 32'(r0_16), 32'(m16[0]));
    chk("REG1_16", 32'(r1_16), 32'(m16[1]));
    chk("REG2_16", 32'(r2_16), 32'(m16[2]));
    chk("REG3_16", 32'(r3_16), 32'(m16[3]));
    chk("REG0_8", 32'(r0_8), 32'(m8[0]));
    chk("REG1_8", 32'(r1_8), 32'(m8[1]));
    chk("REG2_8", 32'(r2_8), 32'(m8[2]));
    chk("REG3_8", 32'(r3_8), 32'(m8[3]));
  endtask

  function automatic void add(input logic rst, input logic wr, input logic rd,
                              input logic [3:0] a, input logic [7:0] d,
                              input logic ev, input logic [7:0] ed16, input logic [7:0] ed8);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.a = a; v.d = d;
    v.ev = ev; v.ed16 = ed16; v.ed8 = ed8;
    tbl.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rv;
    RST = 1'b1; wr_en = 1'b0; rd_en = 1'b0; Addr = '0; wr_data = '0;
    model_reset();

    // Reset, then read back every address.
    add(1, 0, 0, 4'd0, 8'h00, 0, 8'h00, 8'h00);
    add(1, 0, 0, 4'd0, 8'h00, 0, 8'h00, 8'h00);
    for (int i = 0; i < 16; i++) begin
      rv = (i == 2) ? 8'h81 : (i == 3) ? 8'h20 : 8'h00;
      add(0, 0, 1, 4'(i), 8'h00, 1, rv, rv);
    end
    // Write then read, then data holds with valid low.
    add(0, 1, 0, 4'd7, 8'h5A, 0, 8'h00, 8'h00);
    add(0, 0, 1, 4'd7, 8'h00, 1, 8'h5A, 8'h5A);
    add(0, 0, 0, 4'd0, 8'h00, 0, 8'h5A, 8'h5A);
    // Simultaneous write/read: write only, output held.
    add(0, 1, 1, 4'd4, 8'h33, 0, 8'h5A, 8'h5A);
    add(0, 0, 1, 4'd4, 8'h00, 1, 8'h33, 8'h33);
    // Operand registers.
    add(0, 1, 0, 4'd0, 8'h12, 0, 8'h33, 8'h33);
    add(0, 1, 0, 4'd1, 8'h34, 0, 8'h33, 8'h33);
    // Address 9 is out of range only for the DEPTH=8 instance.
    add(0, 1, 0, 4'd9, 8'hFF, 0, 8'h33, 8'h33);
    add(0, 0, 1, 4'd9, 8'h00, 1, 8'hFF, 8'h00);
    add(0, 0, 1, 4'd1, 8'h00, 1, 8'h34, 8'h34);
    add(0, 0, 1, 4'd0, 8'h00, 1, 8'h12, 8'h12);
    add(0, 0, 1, 4'd8, 8'h00, 1, 8'h00, 8'h00);
    add(0, 0, 0, 4'd0, 8'h00, 0, 8'h00, 8'h00);
    // Read followed by reset with rd_en still high: no valid, data cleared.
    add(0, 0, 1, 4'd7, 8'h00, 1, 8'h5A, 8'h5A);
    add(1, 0, 1, 4'd7, 8'h00, 0, 8'h00, 8'h00);
    add(0, 0, 0, 4'd7, 8'h00, 0, 8'h00, 8'h00);
    add(0, 0, 1, 4'd7, 8'h00, 1, 8'h00, 8'h00);
    add(0, 0, 1, 4'd2, 8'h00, 1, 8'h81, 8'h81);
    add(0, 0, 1, 4'd12, 8'h00, 1, 8'h00, 8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d_valid", i), 32'(v16), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_d16", i), 32'(out16), 32'(tbl[i].ed16));
      chk($sformatf("tbl%0d_d8", i), 32'(out8), 32'(tbl[i].ed8));
    end

    // Random tail: mixed reads/writes, held strobes and occasional reset.
    for (int i = 0; i < 80; i++) begin
      drive(($urandom_range(0, 39) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 0),
            4'($urandom_range(0, 15)),
            8'($urandom));
    end

    drive(0, 0, 0, 4'd0, 8'h00);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
